// File: rtl/com_uart_pkg.sv
// Shared definitions for the UART receive path: frame FSM states and default watchdog span.
package com_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  localparam int unsigned DEF_TICK_TIMEOUT = 14000;

endpackage

// File: rtl/com_sync_edge.sv
// N-stage synchroniser (preset high) with one history flop for rise/fall detection.
module com_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic normal_mode_clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              hist;

  always_ff @(posedge normal_mode_clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '1;
      hist  <= 1'b1;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      hist  <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = q & ~hist;
  assign fall = hist & ~q;

endmodule

// File: rtl/com_uart_rx_frame_ctrl.sv
// UART receive frame controller: samples rx_port on falling edges of the timer's
// baudrate_clk, deserialises one frame and hands the word out via valid/ready.
module com_uart_rx_frame_ctrl
  import com_uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned TICK_TIMEOUT = DEF_TICK_TIMEOUT,
  parameter int unsigned TO_WIDTH     = $clog2(TICK_TIMEOUT + 1)
) (
  input  logic                  normal_mode_clk,
  input  logic                  rst_n,
  input  logic                  rx_port,
  input  logic                  baudrate_clk,
  input  logic                  rx_ready,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  stop_cond,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  busy
);

  localparam logic [3:0]          LAST_BIT = 4'(DATA_WIDTH - 1);
  localparam logic [TO_WIDTH-1:0] WD_LAST  = TO_WIDTH'(TICK_TIMEOUT - 1);
  localparam logic                PAR_ODD  = 1'(PARITY_ODD);

  logic rx_s, rx_rise, rx_fall;
  logic bc_s, bc_rise, tick;
  logic unused_edges;

  com_sync_edge #(.STAGES(SYNC_STAGES)) u_rx_sync (
    .normal_mode_clk(normal_mode_clk),
    .rst_n          (rst_n),
    .d              (rx_port),
    .q              (rx_s),
    .rise           (rx_rise),
    .fall           (rx_fall)
  );

  com_sync_edge #(.STAGES(SYNC_STAGES)) u_bc_sync (
    .normal_mode_clk(normal_mode_clk),
    .rst_n          (rst_n),
    .d              (baudrate_clk),
    .q              (bc_s),
    .rise           (bc_rise),
    .fall           (tick)
  );

  assign unused_edges = rx_rise ^ rx_fall ^ bc_s ^ bc_rise;

  rx_state_t             state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [3:0]            bit_cnt;
  logic [TO_WIDTH-1:0]   wd;
  logic                  par_bad;
  logic                  armed;
  logic                  vacant;
  logic                  timeout;

  // A word finishing in the handshake cycle lands in the just-freed slot.
  assign vacant  = !rx_valid || rx_ready;
  assign timeout = !tick && (wd == WD_LAST);

  // Later assignments in this block override the clear/handshake defaults,
  // so a flag set or a new word wins over err_clr or consumption.
  always_ff @(posedge normal_mode_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      wd         <= '0;
      par_bad    <= 1'b0;
      armed      <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      stop_cond  <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      stop_cond <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (err_clr) begin
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
        overrun    <= 1'b0;
      end

      if (state == ST_IDLE) begin
        wd      <= '0;
        bit_cnt <= '0;
        par_bad <= 1'b0;
        // Re-arm only once the line has been seen high again.
        if (rx_s) begin
          armed <= 1'b1;
        end else if (armed) begin
          armed <= 1'b0;
          state <= ST_START;
          busy  <= 1'b1;
        end
      end else if (timeout) begin
        frame_err <= 1'b1;
        stop_cond <= 1'b1;
        state     <= ST_IDLE;
        busy      <= 1'b0;
      end else if (tick) begin
        wd <= '0;
        case (state)
          ST_START: begin
            if (rx_s) begin
              stop_cond <= 1'b1;
              state     <= ST_IDLE;
              busy      <= 1'b0;
            end else begin
              state <= ST_DATA;
            end
          end
          ST_DATA: begin
            shreg   <= {rx_s, shreg[DATA_WIDTH-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) state <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end
          ST_PARITY: begin
            par_bad <= rx_s != ((^shreg) ^ PAR_ODD);
            state   <= ST_STOP;
          end
          ST_STOP: begin
            stop_cond <= 1'b1;
            state     <= ST_IDLE;
            busy      <= 1'b0;
            if (!rx_s) begin
              frame_err <= 1'b1;
            end else if (vacant) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
              if (par_bad) parity_err <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end else begin
        wd <= wd + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_com_uart_rx_frame_ctrl.sv
// Scoreboard bench: an 8N1 and an 8E1 instance driven with bit-banged frames and a timer model.
module tb_com_uart_rx_frame_ctrl;
  timeunit 1ns;
  timeprecision 1ps;

  localparam int unsigned HALF = 8;
  localparam int unsigned TO   = 200;
  localparam int unsigned SYNC = 2;
  localparam int unsigned LAT  = SYNC + 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rx_port_a [2];
  logic       bc_a      [2];
  logic       ready_a   [2];
  logic       err_clr_a [2];
  logic [7:0] rx_data_a [2];
  logic       rx_valid_a[2];
  logic       stop_a    [2];
  logic       pe_a      [2];
  logic       fe_a      [2];
  logic       ov_a      [2];
  logic       busy_a    [2];

  com_uart_rx_frame_ctrl #(
    .DATA_WIDTH(8), .PARITY_EN(0), .PARITY_ODD(0), .SYNC_STAGES(SYNC), .TICK_TIMEOUT(TO)
  ) u_n81 (
    .normal_mode_clk(clk), .rst_n(rst_n), .rx_port(rx_port_a[0]), .baudrate_clk(bc_a[0]),
    .rx_ready(ready_a[0]), .err_clr(err_clr_a[0]), .rx_data(rx_data_a[0]),
    .rx_valid(rx_valid_a[0]), .stop_cond(stop_a[0]), .parity_err(pe_a[0]),
    .frame_err(fe_a[0]), .overrun(ov_a[0]), .busy(busy_a[0])
  );

  com_uart_rx_frame_ctrl #(
    .DATA_WIDTH(8), .PARITY_EN(1), .PARITY_ODD(0), .SYNC_STAGES(SYNC), .TICK_TIMEOUT(TO)
  ) u_8e1 (
    .normal_mode_clk(clk), .rst_n(rst_n), .rx_port(rx_port_a[1]), .baudrate_clk(bc_a[1]),
    .rx_ready(ready_a[1]), .err_clr(err_clr_a[1]), .rx_data(rx_data_a[1]),
    .rx_valid(rx_valid_a[1]), .stop_cond(stop_a[1]), .parity_err(pe_a[1]),
    .frame_err(fe_a[1]), .overrun(ov_a[1]), .busy(busy_a[1])
  );

  typedef struct {
    int          ch;
    int unsigned cyc;
    logic        valid;
    logic [7:0]  data;
    logic        pe;
    logic        fe;
    logic        ov;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference state: what the consumer should observe after each frame.
  logic       m_valid[2];
  logic [7:0] m_data [2];
  logic       m_pe   [2];
  logic       m_fe   [2];
  logic       m_ov   [2];

  logic post_pend [2] = '{1'b0, 1'b0};
  logic post_valid[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int ch = 0; ch < 2; ch++) begin
      m_valid[ch] = 1'b0;
      m_data[ch]  = 8'h00;
      m_pe[ch]    = 1'b0;
      m_fe[ch]    = 1'b0;
      m_ov[ch]    = 1'b0;
    end
  endtask

  // kind: 0 good stop, 1 bad stop, 2 false start, 3 watchdog abort
  task automatic frame_done(input int ch, input int kind, input logic [7:0] data,
                            input bit par_ok, input int unsigned c);
    exp_t e;
    case (kind)
      0: begin
        if (m_valid[ch]) m_ov[ch] = 1'b1;
        else begin
          m_valid[ch] = 1'b1;
          m_data[ch]  = data;
          if (!par_ok) m_pe[ch] = 1'b1;
        end
      end
      1, 3: m_fe[ch] = 1'b1;
      default: ;
    endcase
    e.ch    = ch;
    e.cyc   = c + LAT + ((kind == 3) ? TO : 0);
    e.valid = m_valid[ch];
    e.data  = m_data[ch];
    e.pe    = m_pe[ch];
    e.fe    = m_fe[ch];
    e.ov    = m_ov[ch];
    sbq.push_back(e);
    if (ready_a[ch]) m_valid[ch] = 1'b0;
  endtask

  task automatic drain(input int unsigned limit);
    int unsigned n = 0;
    while (sbq.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL stop_cond_wait: got no pulse expected one within %0d cycles", limit);
      sbq.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic bit_first_half(input int ch, input logic b);
    rx_port_a[ch] = b;
    bc_a[ch]      = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic bit_second_half(input int ch);
    bc_a[ch] = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic send_frame(input int ch, input logic [7:0] data, input bit bad_par, input logic stop_bit);
    logic par;
    int unsigned c;
    bit_first_half(ch, 1'b0);
    bit_second_half(ch);
    for (int i = 0; i < 8; i++) begin
      bit_first_half(ch, data[i]);
      bit_second_half(ch);
    end
    if (ch == 1) begin
      par = ($countones(data) % 2) == 1;
      if (bad_par) par = !par;
      bit_first_half(ch, par);
      bit_second_half(ch);
    end
    bit_first_half(ch, stop_bit);
    bc_a[ch] = 1'b0;
    c = cyc;
    frame_done(ch, stop_bit ? 0 : 1, data, (ch == 0) || !bad_par, c);
    repeat (HALF) @(negedge clk);
    rx_port_a[ch] = 1'b1;
    drain(4 * HALF);
  endtask

  task automatic false_start(input int ch);
    int unsigned c;
    rx_port_a[ch] = 1'b0;
    bc_a[ch]      = 1'b1;
    repeat (HALF / 2) @(negedge clk);
    rx_port_a[ch] = 1'b1;
    repeat (HALF / 2) @(negedge clk);
    bc_a[ch] = 1'b0;
    c = cyc;
    frame_done(ch, 2, 8'h00, 1'b1, c);
    repeat (HALF) @(negedge clk);
    drain(4 * HALF);
  endtask

  task automatic timeout_frame(input int ch);
    int unsigned c;
    bit_first_half(ch, 1'b0);
    bc_a[ch] = 1'b0;
    c = cyc;
    frame_done(ch, 3, 8'h00, 1'b1, c);
    repeat (HALF) @(negedge clk);
    rx_port_a[ch] = 1'b0;
    drain(TO + 50);
    rx_port_a[ch] = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic set_ready(input int ch, input logic v);
    ready_a[ch] = v;
    if (v) m_valid[ch] = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_err_clr(input int ch);
    err_clr_a[ch] = 1'b1;
    @(negedge clk);
    err_clr_a[ch] = 1'b0;
    m_pe[ch] = 1'b0;
    m_fe[ch] = 1'b0;
    m_ov[ch] = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input int ch);
    check("rst_rx_data",    rx_data_a[ch],  0);
    check("rst_rx_valid",   rx_valid_a[ch], 0);
    check("rst_stop_cond",  stop_a[ch],     0);
    check("rst_parity_err", pe_a[ch],       0);
    check("rst_frame_err",  fe_a[ch],       0);
    check("rst_overrun",    ov_a[ch],       0);
    check("rst_busy",       busy_a[ch],     0);
  endtask

  task automatic reset_mid_data(input int ch);
    bit_first_half(ch, 1'b0);
    bit_second_half(ch);
    for (int i = 0; i < 3; i++) begin
      bit_first_half(ch, 1'($urandom));
      bit_second_half(ch);
    end
    rx_port_a[ch] = 1'b1;
    bc_a[ch]      = 1'b1;
    @(negedge clk);
    check("busy_mid_frame", busy_a[ch], 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs(0);
    check_reset_outputs(1);
    bc_a[ch] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (10) @(negedge clk);
  endtask

  always @(negedge clk) begin
    for (int ch = 0; ch < 2; ch++) begin
      if (post_pend[ch]) begin
        post_pend[ch] = 1'b0;
        check("stop_cond_width", stop_a[ch], 0);
        check("rx_valid_next", rx_valid_a[ch], post_valid[ch]);
      end else if (stop_a[ch]) begin
        n_cmp++;
        if (sbq.size() == 0 || sbq[0].ch != ch) begin
          n_bad++;
          $display("FAIL stop_cond_unexpected: got pulse on ch%0d expected none (cycle %0d)", ch, cyc);
        end else begin
          mon_e = sbq.pop_front();
          check("stop_cond_cycle", cyc, mon_e.cyc);
          check("rx_valid", rx_valid_a[ch], mon_e.valid);
          if (mon_e.valid) check("rx_data", rx_data_a[ch], mon_e.data);
          check("parity_err", pe_a[ch], mon_e.pe);
          check("frame_err",  fe_a[ch], mon_e.fe);
          check("overrun",    ov_a[ch], mon_e.ov);
          post_pend[ch]  = 1'b1;
          post_valid[ch] = mon_e.valid && !ready_a[ch];
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: got no completion expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int ch;
    int unsigned r;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rx_port_a[i] = 1'b1;
      bc_a[i]      = 1'b0;
      ready_a[i]   = 1'b1;
      err_clr_a[i] = 1'b0;
    end
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs(0);
    check_reset_outputs(1);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    send_frame(0, 8'h55, 1'b0, 1'b1);
    send_frame(1, 8'hA3, 1'b1, 1'b1);
    pulse_err_clr(1);
    send_frame(1, 8'h3C, 1'b0, 1'b1);
    send_frame(0, 8'h0F, 1'b0, 1'b0);
    pulse_err_clr(0);
    false_start(0);
    set_ready(0, 1'b0);
    send_frame(0, 8'h11, 1'b0, 1'b1);
    send_frame(0, 8'h22, 1'b0, 1'b1);
    reset_mid_data(0);
    set_ready(0, 1'b1);
    timeout_frame(1);
    pulse_err_clr(1);

    for (int i = 0; i < 40; i++) begin
      ch = int'($urandom_range(0, 1));
      r  = $urandom_range(0, 99);
      if ($urandom_range(0, 3) == 0) set_ready(ch, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 5) == 0) pulse_err_clr(ch);
      if (r < 70)      send_frame(ch, 8'($urandom), $urandom_range(0, 3) == 0, 1'b1);
      else if (r < 82) send_frame(ch, 8'($urandom), 1'b0, 1'b0);
      else if (r < 94) false_start(ch);
      else             timeout_frame(ch);
      repeat ($urandom_range(1, 10)) @(negedge clk);
    end

    check("scoreboard_empty", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/com_uart_rx_frame_ctrl.md
Name: com_uart_rx_frame_ctrl

Overview:
- Receive-side frame controller placed directly downstream of com_uart_receiver_timer.
- Consumes that timer's baudrate_clk together with rx_port, and deserialises one UART frame: start bit, data LSB-first, optional parity, one stop bit.
- Returns stop_cond to the timer so the timer halts between frames.
- Presents each received byte through a valid/ready handshake to the RX FIFO.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (5..8).
- PARITY_EN, 0, 1 = a parity bit follows the data bits.
- PARITY_ODD, 0, 1 = odd parity, 0 = even parity; ignored when PARITY_EN=0.
- SYNC_STAGES, 2, depth of the synchroniser on both rx_port and baudrate_clk (minimum 2).
- TICK_TIMEOUT, 14000, number of normal_mode_clk cycles without a sample tick before an in-frame abort.
- TO_WIDTH, $clog2(TICK_TIMEOUT+1), width of the watchdog counter.

Ports:
- normal_mode_clk  in  1  block clock; every flop in the block is on its posedge.
- rst_n  in  1  reset; asynchronous, active-low.
- rx_port  in  1  serial line; idle high.
- baudrate_clk  in  1  bit-rate clock from the timer; asynchronous to normal_mode_clk.
- rx_ready  in  1  consumer accepts rx_data.
- err_clr  in  1  one-cycle pulse that clears the sticky error flags.
- rx_data  out  DATA_WIDTH  received word.
- rx_valid  out  1  rx_data holds an unconsumed word.
- stop_cond  out  1  one-cycle pulse to the timer marking end of frame or abort.
- parity_err  out  1  sticky parity error flag.
- frame_err  out  1  sticky flag: stop bit sampled 0, or watchdog timeout.
- overrun  out  1  sticky flag: a frame completed while rx_valid was still high.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: rx_data=0, rx_valid=0, stop_cond=0, parity_err=0, frame_err=0, overrun=0, busy=0; FSM in IDLE; synchronisers preset to 1.
- rx_s = rx_port after SYNC_STAGES flops. bc_s = baudrate_clk after SYNC_STAGES flops, plus one history flop.
- tick = bc_s falling edge (history=1, current=0). The timer raises baudrate_clk at the start of the start bit, so each falling edge is mid-bit.
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE: rx_s==0 -> START; clear bit_cnt and watchdog.
  - START, on tick: rx_s==1 is a false start -> pulse stop_cond, go to IDLE, no flags set. rx_s==0 -> DATA.
  - DATA, on tick: shift rx_s into shreg[DATA_WIDTH-1] and shift right; bit_cnt++. When bit_cnt==DATA_WIDTH-1 -> PARITY if PARITY_EN, else STOP.
  - PARITY, on tick: compare rx_s with (^shreg)^PARITY_ODD; record the mismatch in a local flag -> STOP.
  - STOP, on tick: pulse stop_cond the next cycle; return to IDLE.
    - rx_s==0: set frame_err; discard the word.
    - rx_s==1 and rx_valid==0: load rx_data, set rx_valid, and apply the local parity flag to parity_err.
    - rx_s==1 and rx_valid==1: set overrun; keep the old rx_data.
- Handshake: rx_valid && rx_ready drops rx_valid in the next cycle. rx_data stays stable while rx_valid=1. A frame completing in the same cycle as the handshake is accepted, not an overrun.
- Latency: rx_valid rises 1 cycle after the stop-bit tick. stop_cond is asserted exactly 1 cycle, then held 0 for at least 1 cycle.
- Watchdog: counts cycles in every non-IDLE state and resets on each tick. At TICK_TIMEOUT it sets frame_err, pulses stop_cond and returns to IDLE.
- Every exit from a non-IDLE state pulses stop_cond exactly once.
- IDLE re-arms only after the stop pulse, so the same low level does not immediately restart a frame until rx_s has returned to 1.
- Simultaneous err_clr and error set in one cycle: the set wins.
- rst_n low mid-frame: abort immediately to reset values; stop_cond is not pulsed.

Decomposition:
- com_uart_pkg holds the FSM state encoding constants and the default TICK_TIMEOUT.
- One natural sub-module: com_sync_edge, an N-stage synchroniser with rise/fall outputs, instantiated once for rx_port and once for baudrate_clk.

Test Plan:
- 8N1, 0x55 framed at the timer bit period, rx_ready=1 -> rx_data=0x55, rx_valid for 1 cycle, one stop_cond pulse, no flags set.
- PARITY_EN=1, even parity, byte 0xA3 sent with parity bit 1 -> parity_err=1, rx_data=0xA3; err_clr pulse -> parity_err=0.
- Byte 0x0F sent with stop bit 0 -> frame_err=1, rx_valid stays 0, stop_cond pulsed.
- rx_port low for 1/4 bit then high (glitch) -> return to IDLE after the first tick, stop_cond pulsed, no flags set, no rx_valid.
- Two frames 0x11 then 0x22 with rx_ready=0 -> rx_data=0x11 retained, overrun=1.
- baudrate_clk held static after the start bit -> frame_err and stop_cond exactly TICK_TIMEOUT cycles after the last tick. Separately, rst_n pulsed mid-DATA -> all outputs at reset values and no stop_cond pulse.
